// File: rtl/pinky_pkg.sv
// pinky_pkg: opcode/cc encodings, instruction field ranges, scoreboard entry and decode helpers
package pinky_pkg;
  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPADDF = 5'd1;
  localparam logic [4:0] OPAND  = 5'd2;
  localparam logic [4:0] OPBIC  = 5'd3;
  localparam logic [4:0] OPEOR  = 5'd4;
  localparam logic [4:0] OPMUL  = 5'd5;
  localparam logic [4:0] OPMULF = 5'd6;
  localparam logic [4:0] OPORR  = 5'd7;
  localparam logic [4:0] OPSHA  = 5'd8;
  localparam logic [4:0] OPSLT  = 5'd9;
  localparam logic [4:0] OPSUB  = 5'd10;
  localparam logic [4:0] OPSUBF = 5'd11;
  localparam logic [4:0] OPSTR  = 5'd12;
  localparam logic [4:0] OPMOV  = 5'd13;
  localparam logic [4:0] OPLDR  = 5'd14;
  localparam logic [4:0] OPSYS  = 5'd15;
  localparam logic [4:0] OPNOP  = 5'd16;
  localparam logic [4:0] OPPRE  = 5'd17;
  localparam logic [1:0] CC_AL = 2'd0;
  localparam logic [1:0] CC_S  = 2'd1;
  localparam logic [1:0] CC_NE = 2'd2;
  localparam logic [1:0] CC_EQ = 2'd3;
  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int CC_HI = 10;
  localparam int CC_LO = 9;
  localparam int IMM_B = 8;
  localparam int RD_HI = 7;
  localparam int RD_LO = 4;
  localparam int R2_HI = 3;
  localparam int R2_LO = 0;
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       setcc;
  } sb_entry_t;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_DRAIN, ST_HALTED} state_t;
  function automatic logic quiet_op(input logic [4:0] op);
    return op inside {OPSYS, OPNOP, OPPRE};
  endfunction
  function automatic logic writes_rd(input logic [4:0] op);
    return !(op inside {OPSTR, OPSYS, OPNOP, OPPRE});
  endfunction
  function automatic logic reads_rd(input logic [4:0] op);
    return op inside {OPADD, OPADDF, OPAND, OPBIC, OPEOR, OPMUL, OPMULF,
                      OPORR, OPSHA, OPSLT, OPSUB, OPSUBF, OPSTR};
  endfunction
  function automatic logic reads_op2(input logic [15:0] ir);
    return !ir[IMM_B] && !quiet_op(ir[OP_HI:OP_LO]);
  endfunction
endpackage

// File: rtl/pinky_issue_ctl_if.sv
// pinky_issue_ctl_if: decode-side request and interlock status bundle of the issue controller
interface pinky_issue_ctl_if #(parameter int CNTW = 16);
  logic            dec_valid;
  logic [15:0]     dec_ir;
  logic            wb_z;
  logic            stall;
  logic            bubble;
  logic            z_flag;
  logic            halt;
  logic [CNTW-1:0] stall_cnt;
  modport master (output dec_valid, dec_ir, wb_z, input stall, bubble, z_flag, halt, stall_cnt);
  modport slave (input dec_valid, dec_ir, wb_z, output stall, bubble, z_flag, halt, stall_cnt);
endinterface

// File: rtl/pinky_scoreboard.sv
// pinky_scoreboard: shift array of in-flight register writes with dest match and setcc lookups
module pinky_scoreboard
  import pinky_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  sb_entry_t i_push,
  input  logic [3:0] i_rd_a,
  input  logic [3:0] i_rd_b,
  output logic      o_hit_a,
  output logic      o_hit_b,
  output logic      o_any_setcc,
  output logic      o_empty,
  output logic      o_ret_setcc
);
  sb_entry_t r_sb [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= i_push;
      for (int i = 1; i < DEPTH; i++) r_sb[i] <= r_sb[i-1];
    end
  // the retiring entry is still searched: there is no bypass path
  always_comb begin
    o_hit_a = 1'b0;
    o_hit_b = 1'b0;
    o_any_setcc = 1'b0;
    o_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit_a |= r_sb[i].valid && r_sb[i].dest == i_rd_a;
      o_hit_b |= r_sb[i].valid && r_sb[i].dest == i_rd_b;
      o_any_setcc |= r_sb[i].valid && r_sb[i].setcc;
      o_empty &= !r_sb[i].valid;
    end
  end
  assign o_ret_setcc = r_sb[DEPTH-1].valid && r_sb[DEPTH-1].setcc;
endmodule

// File: rtl/pinky_issue_ctl.sv
// pinky_issue_ctl: RAW interlock, Z flag ownership and SYS drain-then-halt sequencing for PinKY
module pinky_issue_ctl
  import pinky_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input logic              clk,
  input logic              reset,
  pinky_issue_ctl_if.slave bus
);
  state_t          r_state, w_next;
  logic            r_z;
  logic [CNTW-1:0] r_cnt;
  logic [4:0]      w_op;
  logic [1:0]      w_cc;
  logic            w_hit_rd, w_hit_op2, w_any_setcc, w_empty, w_ret_setcc;
  logic            w_active, w_hazard, w_issue, w_stall;
  sb_entry_t       w_push;
  assign w_op = bus.dec_ir[OP_HI:OP_LO];
  assign w_cc = bus.dec_ir[CC_HI:CC_LO];
  assign w_active = r_state == ST_RUN || r_state == ST_STALL;
  assign w_hazard = bus.dec_valid && !quiet_op(w_op) &&
                    ((reads_rd(w_op) && w_hit_rd) ||
                     (reads_op2(bus.dec_ir) && w_hit_op2) ||
                     ((w_cc == CC_NE || w_cc == CC_EQ) && w_any_setcc));
  // a stalled instruction issues on the very edge its hazard clears
  assign w_issue = bus.dec_valid && !w_hazard && w_active;
  assign w_push = '{valid: w_issue && writes_rd(w_op),
                    dest:  bus.dec_ir[RD_HI:RD_LO],
                    setcc: w_cc == CC_S && writes_rd(w_op)};
  pinky_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_rd_a(bus.dec_ir[RD_HI:RD_LO]),
    .i_rd_b(bus.dec_ir[R2_HI:R2_LO]),
    .o_hit_a(w_hit_rd),
    .o_hit_b(w_hit_op2),
    .o_any_setcc(w_any_setcc),
    .o_empty(w_empty),
    .o_ret_setcc(w_ret_setcc)
  );
  always_comb begin
    w_next = w_active ? (w_hazard ? ST_STALL : (w_issue && w_op == OPSYS) ? ST_DRAIN : ST_RUN)
                      : (r_state == ST_DRAIN && !w_empty) ? ST_DRAIN : ST_HALTED;
    w_stall = !w_active || w_hazard;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ST_RUN;
      r_z <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_ret_setcc) r_z <= bus.wb_z;
      if (w_active && w_hazard && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  assign bus.stall = w_stall;
  assign bus.bubble = w_stall;
  assign bus.z_flag = r_z;
  assign bus.halt = r_state == ST_HALTED;
  assign bus.stall_cnt = r_cnt;
endmodule

// File: tb/tb_pinky_issue_ctl.sv
// tb_pinky_issue_ctl: directed and random stimulus against a timestamp-based interlock model
module tb_pinky_issue_ctl;
  import pinky_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  pinky_issue_ctl_if #(.CNTW(16)) bus ();
  pinky_issue_ctl_if #(.CNTW(4)) bus4 ();
  assign bus4.dec_valid = bus.dec_valid;
  assign bus4.dec_ir = bus.dec_ir;
  assign bus4.wb_z = bus.wb_z;
  pinky_issue_ctl #(.DEPTH(DEPTH), .CNTW(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  pinky_issue_ctl #(.DEPTH(DEPTH), .CNTW(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  always #5 clk = ~clk;
  // model: each write is remembered by the edge index at which it issued
  int cyc, last_any, last_sc, cnt;
  int last_wr [16];
  bit sc_at [int];
  bit z_m, draining, halted;
  function automatic bit busy(input int e);
    return (cyc - e) < DEPTH;
  endfunction
  function automatic logic [15:0] ins(input logic [4:0] op, input logic [1:0] cc, input logic imm,
                                      input logic [3:0] rd, input logic [3:0] r2);
    return {op, cc, imm, rd, r2};
  endfunction
  function automatic logic [15:0] rand_ir();
    return ins(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    cyc = 0; last_any = -100; last_sc = -100; cnt = 0;
    for (int i = 0; i < 16; i++) last_wr[i] = -100;
    sc_at.delete();
    z_m = 0; draining = 0; halted = 0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_bubble", bus.bubble, 0);
    chk("rst_z", bus.z_flag, 0);
    chk("rst_halt", bus.halt, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_cnt4", bus4.stall_cnt, 0);
    model_reset();
    bus.dec_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic step(input logic v, input logic [15:0] ir, input logic wz, output logic st);
    logic [4:0] op;
    logic [1:0] cc;
    logic [3:0] rd, r2;
    bit quiet, wr, rrd, hz, exp_st, iss;
    @(negedge clk);
    bus.dec_valid = v;
    bus.dec_ir = ir;
    bus.wb_z = wz;
    #1;
    op = ir[15:11]; cc = ir[10:9]; rd = ir[7:4]; r2 = ir[3:0];
    quiet = op == OPSYS || op == OPNOP || op == OPPRE;
    wr = !quiet && op != OPSTR;
    rrd = op inside {OPADD, OPADDF, OPAND, OPBIC, OPEOR, OPMUL, OPMULF, OPORR,
                     OPSHA, OPSLT, OPSUB, OPSUBF, OPSTR};
    hz = v && !quiet && ((rrd && busy(last_wr[rd])) || (!ir[8] && busy(last_wr[r2])) ||
                         ((cc == CC_NE || cc == CC_EQ) && busy(last_sc)));
    exp_st = draining || halted || hz;
    iss = v && !hz && !draining && !halted;
    chk("stall", bus.stall, exp_st);
    chk("bubble", bus.bubble, exp_st);
    chk("z_flag", bus.z_flag, z_m);
    chk("halt", bus.halt, halted);
    chk("stall_cnt", bus.stall_cnt, cnt);
    chk("stall_cnt4", bus4.stall_cnt, cnt > 15 ? 15 : cnt);
    st = bus.stall;
    @(posedge clk);
    if (sc_at.exists(cyc - DEPTH + 1)) z_m = wz;
    if (hz && !draining && !halted) cnt++;
    if (draining && cyc - last_any >= DEPTH) begin draining = 0; halted = 1; end
    cyc++;
    if (iss && wr) begin
      last_wr[rd] = cyc;
      last_any = cyc;
      if (cc == CC_S) begin last_sc = cyc; sc_at[cyc] = 1; end
    end
    if (iss && op == OPSYS) draining = 1;
    #1;
  endtask
  task automatic issue(input logic [15:0] ir, input logic wz, output int n);
    logic st;
    n = 0;
    do begin
      step(1'b1, ir, wz, st);
      if (st) n++;
    end while (st && n < 20);
  endtask
  initial begin
    int n, k;
    logic st, cur_v;
    logic [15:0] cur_ir;
    st = 1'b0; cur_v = 1'b0; cur_ir = '0;
    bus.dec_valid = 1'b0; bus.dec_ir = '0; bus.wb_z = 1'b0;
    do_reset();
    issue(ins(OPADD, CC_AL, 0, 1, 2), 0, n); chk("raw_producer", n, 0);
    issue(ins(OPSUB, CC_AL, 0, 3, 1), 0, n); chk("raw_stalls", n, 2);
    chk("raw_cnt", bus.stall_cnt, 2);
    issue(ins(OPMOV, CC_AL, 1, 1, 3), 0, n); chk("mov_imm", n, 0);
    issue(ins(OPADD, CC_AL, 1, 4, 5), 0, n); chk("indep_add", n, 0);
    issue(ins(OPMOV, CC_AL, 1, 5, 1), 0, n); chk("mov_r5", n, 0);
    issue(ins(OPPRE, CC_EQ, 0, 5, 5), 0, n); chk("pre_nostall", n, 0);
    issue(ins(OPADD, CC_AL, 1, 5, 7), 0, n); chk("pre_dep_add", n, 1);
    repeat (3) step(1'b0, 16'h0, 1'b0, st);
    chk("z_before", bus.z_flag, 0);
    issue(ins(OPSUB, CC_S, 1, 1, 0), 1, n); chk("subs_issue", n, 0);
    issue(ins(OPADD, CC_EQ, 1, 8, 1), 1, n); chk("eq_stalls", n, 2);
    chk("z_set", bus.z_flag, 1);
    repeat (3) step(1'b0, 16'h0, 1'b1, st);
    issue(ins(OPSUB, CC_S, 1, 2, 0), 0, n); chk("subs2_issue", n, 0);
    issue(ins(OPADD, CC_NE, 1, 9, 1), 0, n); chk("ne_stalls", n, 2);
    chk("z_clear", bus.z_flag, 0);
    for (int i = 0; i < 10; i++) begin
      issue(ins(OPMOV, CC_AL, 1, 11, 0), 0, n);
      issue(ins(OPADD, CC_AL, 0, 12, 11), 0, n);
    end
    chk("sat_cnt4", bus4.stall_cnt, 15);
    chk("sat_cnt16", bus.stall_cnt, 27);
    repeat (3) step(1'b0, 16'h0, 1'b0, st);
    issue(ins(OPMOV, CC_AL, 1, 9, 0), 0, n);
    issue(ins(OPMOV, CC_AL, 1, 10, 0), 0, n);
    issue(ins(OPSYS, CC_AL, 0, 0, 0), 0, n); chk("sys_issue", n, 0);
    k = 0;
    while (!bus.halt && k < 10) begin step(1'b1, rand_ir(), 1'b0, st); k++; end
    chk("drain_cycles", k, 2);
    repeat (3) step(1'b1, ins(OPMOV, CC_S, 1, 1, 0), 1'b1, st);
    chk("halt_hold", bus.halt, 1);
    do_reset();
    issue(ins(OPMOV, CC_AL, 1, 1, 0), 0, n);
    @(negedge clk);
    bus.dec_valid = 1'b1;
    bus.dec_ir = ins(OPADD, CC_AL, 0, 2, 1);
    #1;
    chk("pre_rst_hazard", bus.stall, 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!(st && !bus.halt)) begin
        cur_v = $urandom_range(0, 9) < 8;
        cur_ir = ($urandom_range(0, 63) == 0) ? ins(OPSYS, CC_AL, 0, 0, 0) : rand_ir();
      end
      step(cur_v, cur_ir, 1'($urandom_range(0, 1)), st);
      if (bus.halt && $urandom_range(0, 7) == 0) begin
        do_reset();
        st = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
